// File: rtl/kyber_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kyber_pkg : shared ML-KEM constants, coefficient type, encoder FSM  |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int POLY_W  = 4096;
  localparam int COEF_W  = 16;

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/coef_canon.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | coef_canon : maps x < 2q to x mod q, returning the low OUT_W bits   |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
module coef_canon
  import kyber_pkg::*;
#(
  parameter int OUT_W = 12
) (
  input  coef_t             x_i,
  output logic [OUT_W-1:0]  y_o
);

  localparam coef_t Q_C = coef_t'(KYBER_Q);

  logic ge;

  // Low bits of a difference depend only on low bits of the operands.
  assign ge  = (x_i >= Q_C);
  assign y_o = x_i[OUT_W-1:0] - (ge ? Q_C[OUT_W-1:0] : '0);

endmodule
`default_nettype wire

// File: rtl/poly_byte_encode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | poly_byte_encode : serialises a 256-coefficient poly into the       |
// | ByteEncode_D byte stream. Define POLY_ENCODE_REDUCE_EN to reduce     |
// | coefficients mod q on the fill path.                                 |
// | Revision : 1.0                                                       |
// +--------------------------------------------------------------------+
module poly_byte_encode
  import kyber_pkg::*;
#(
  parameter int D = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [POLY_W-1:0] in_poly,
  input  logic [3:0]        in_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [3:0]        out_index,
  output logic              done
);

  localparam int BYTES  = 32 * D;
  // Narrow coefficients are packed several per cycle to keep the byte rate up.
  localparam int FILL_N = (D < 8) ? (8 / D) : 1;
  localparam int FILL_W = FILL_N * D;
  localparam int ROT_W  = FILL_N * COEF_W;
  localparam int ACC_W  = 20;

  enc_state_t        state_q;
  logic              in_ready_q;
  logic [POLY_W-1:0] poly_q;
  logic [3:0]        index_q;
  logic [8:0]        coef_cnt_q;
  logic [8:0]        byte_cnt_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [4:0]        acc_bits_q, acc_bits_d;

  logic              drain;
  logic              fill;
  logic [ACC_W-1:0]  acc_shift;
  logic [4:0]        bits_left;
  logic [FILL_W-1:0] fill_word;

  for (genvar j = 0; j < FILL_N; j++) begin : g_fill
`ifdef POLY_ENCODE_REDUCE_EN
    coef_canon #(
      .OUT_W (D)
    ) u_canon (
      .x_i (poly_q[j*COEF_W +: COEF_W]),
      .y_o (fill_word[j*D +: D])
    );
`else
    assign fill_word[j*D +: D] = poly_q[j*COEF_W +: D];
`endif
  end

  assign out_valid = (state_q == PACK) && (acc_bits_q >= 5'd8);
  assign out_byte  = acc_q[7:0];
  assign out_last  = out_valid && (byte_cnt_q == 9'(BYTES - 1));
  assign out_index = index_q;
  assign in_ready  = in_ready_q;
  assign done      = (state_q == DONE);

  // Fill decisions look at the post-drain bit count so fill and drain overlap.
  always_comb begin
    drain      = out_valid && out_ready;
    acc_shift  = drain ? (acc_q >> 8) : acc_q;
    bits_left  = drain ? (acc_bits_q - 5'd8) : acc_bits_q;
    fill       = (state_q == PACK) && (bits_left < 5'd8) && (coef_cnt_q < 9'(KYBER_N));
    acc_d      = fill ? (acc_shift | (ACC_W'(fill_word) << bits_left)) : acc_shift;
    acc_bits_d = fill ? (bits_left + 5'(FILL_W)) : bits_left;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      poly_q     <= '0;
      index_q    <= '0;
      coef_cnt_q <= '0;
      byte_cnt_q <= '0;
      acc_q      <= '0;
      acc_bits_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            poly_q     <= in_poly;
            index_q    <= in_index;
            coef_cnt_q <= '0;
            byte_cnt_q <= '0;
            acc_q      <= '0;
            acc_bits_q <= '0;
            in_ready_q <= 1'b0;
            state_q    <= PACK;
          end
        end
        PACK: begin
          acc_q      <= acc_d;
          acc_bits_q <= acc_bits_d;
          if (fill) begin
            poly_q     <= {poly_q[ROT_W-1:0], poly_q[POLY_W-1:ROT_W]};
            coef_cnt_q <= coef_cnt_q + 9'(FILL_N);
          end
          if (drain) begin
            byte_cnt_q <= byte_cnt_q + 9'd1;
            if (out_last) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
